// File: rtl/crc_pkg.sv
// Shared CRC-32 (poly 0x04C11DB7) definitions: default constants, engine FSM
// states and bit-reversal helpers used for the reflected configuration.
package crc_pkg;

   localparam logic [31:0] CRC32_POLY     = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32_INIT_DEF = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_XOR_DEF  = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ACCEPT,
      SHIFT,
      RESULT
   } crc_state_e;

   function automatic logic [7:0] bitrev8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = d[7-i];
      end
      return r;
   endfunction

   function automatic logic [31:0] bitrev32(input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = d[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc32_04c11db7.sv
// Combinational CRC-32 byte step, MSB-first: shifts data_i[7] in first,
// polynomial 0x04C11DB7, no reflection or final XOR of its own.
module crc32_04c11db7
   import crc_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   always_comb begin
      logic [31:0] c;
      c = crc_i;
      // NOTE: blocking assignments are required here so each bit step sees the
      // result of the previous one within the same evaluation.
      for (int i = 7; i >= 0; i--) begin
         if (c[31] ^ data_i[i]) begin
            c = {c[30:0], 1'b0} ^ CRC32_POLY;
         end else begin
            c = {c[30:0], 1'b0};
         end
      end
      crc_o = c;
   end

endmodule

// File: rtl/crc32_stream_engine.sv
// Word-stream CRC-32 engine: accepts 32-bit words over valid/ready, feeds one
// byte per cycle to crc32_04c11db7 and presents the final CRC over valid/ready.
// Optional build macro CRC32_REFLECT_EN selects reflected input/output bit order.
module crc32_stream_engine
   import crc_pkg::*;
#(
   parameter logic [31:0] INIT_VAL = CRC32_INIT_DEF,
   parameter logic [31:0] XOR_OUT  = CRC32_XOR_DEF
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        clr_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_data_i,
   input  logic        in_last_i,
   input  logic [1:0]  in_nbytes_i,
   output logic        crc_valid_o,
   input  logic        crc_ready_i,
   output logic [31:0] crc_o,
   output logic        busy_o
);

   crc_state_e  state_q, state_d;
   logic [31:0] crc_q;
   logic [31:0] word_q;
   logic        last_q;
   logic [1:0]  nmax_q;
   logic [1:0]  cnt_q;

   logic [7:0]  byte_raw;
   logic [7:0]  byte_core;
   logic [31:0] crc_step;
   logic [31:0] crc_mapped;
   logic        accept;

   assign byte_raw = word_q[{cnt_q, 3'b000} +: 8];

`ifdef CRC32_REFLECT_EN
   assign byte_core  = bitrev8(byte_raw);
   assign crc_mapped = bitrev32(crc_q);
`else
   assign byte_core  = byte_raw;
   assign crc_mapped = crc_q;
`endif

   crc32_04c11db7 u_core (
      .crc_i  (crc_q),
      .data_i (byte_core),
      .crc_o  (crc_step)
   );

   assign accept = in_ready_o && in_valid_i;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can
      // leave a value unassigned and infer a latch.
      state_d     = state_q;
      in_ready_o  = 1'b0;
      crc_valid_o = 1'b0;
      crc_o       = 32'h0;
      busy_o      = 1'b0;
      case (state_q)
         ACCEPT: begin
            in_ready_o = 1'b1;
            if (in_valid_i) state_d = SHIFT;
         end
         SHIFT: begin
            busy_o = 1'b1;
            if (cnt_q == nmax_q) state_d = last_q ? RESULT : ACCEPT;
         end
         RESULT: begin
            busy_o      = 1'b1;
            crc_valid_o = 1'b1;
            crc_o       = crc_mapped ^ XOR_OUT;
            if (crc_ready_i) state_d = ACCEPT;
         end
         default: state_d = ACCEPT;
      endcase
      // Abort hides the pending result so a consumer cannot take a dropped CRC.
      if (clr_i) begin
         crc_valid_o = 1'b0;
         crc_o       = 32'h0;
      end
      if (!rst_n_i || clr_i) begin
         in_ready_o = 1'b0;
         state_d    = ACCEPT;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= ACCEPT;
         crc_q   <= INIT_VAL;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         if (clr_i) begin
            crc_q <= INIT_VAL;
            cnt_q <= 2'd0;
         end else begin
            case (state_q)
               ACCEPT: begin
                  if (in_valid_i) cnt_q <= 2'd0;
               end
               SHIFT: begin
                  crc_q <= crc_step;
                  cnt_q <= cnt_q + 2'd1;
               end
               RESULT: begin
                  if (crc_ready_i) crc_q <= INIT_VAL;
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: the word holding registers carry no reset; they are only read in
   // SHIFT, which is reachable solely through a handshake that loads them.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         word_q <= in_data_i;
         last_q <= in_last_i;
         nmax_q <= in_last_i ? in_nbytes_i : 2'd3;
      end
   end

endmodule

// File: tb/tb_crc32_stream_engine.sv
// Self-checking bench for crc32_stream_engine: directed reference vectors plus
// randomized messages checked against a bitwise CRC model held in the bench.
module tb_crc32_stream_engine;

   logic        clk_i = 1'b0;
   logic        rst_n_i, clr_i, in_valid_i, in_last_i, crc_ready_i;
   logic [31:0] in_data_i;
   logic [1:0]  in_nbytes_i;
   logic        in_ready_o, crc_valid_o, busy_o;
   logic [31:0] crc_o;
   logic        in_ready_z, crc_valid_z, busy_z;
   logic [31:0] crc_z;

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_z_q[$];
   logic        prev_valid = 1'b0;
   logic        prev_hs    = 1'b0;
   logic [31:0] prev_crc   = 32'h0;

`ifdef CRC32_REFLECT_EN
   localparam logic [31:0] LIT_CHECK   = 32'hCBF4_3926;
   localparam logic [31:0] LIT_CHECK_Z = 32'h340B_C6D9;
`else
   localparam logic [31:0] LIT_CHECK   = 32'hFC89_1918;
   localparam logic [31:0] LIT_CHECK_Z = 32'h0376_E6E7;
`endif

   always #5 clk_i = ~clk_i;

   crc32_stream_engine dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .clr_i       (clr_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .in_last_i   (in_last_i),
      .in_nbytes_i (in_nbytes_i),
      .crc_valid_o (crc_valid_o),
      .crc_ready_i (crc_ready_i),
      .crc_o       (crc_o),
      .busy_o      (busy_o)
   );

   crc32_stream_engine #(.XOR_OUT(32'h0)) dut_z (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .clr_i       (clr_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_z),
      .in_data_i   (in_data_i),
      .in_last_i   (in_last_i),
      .in_nbytes_i (in_nbytes_i),
      .crc_valid_o (crc_valid_z),
      .crc_ready_i (crc_ready_i),
      .crc_o       (crc_z),
      .busy_o      (busy_z)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference CRC over a whole byte message, written as the textbook bitwise
   // algorithm (reflected register form when reflection is enabled).
   function automatic logic [31:0] model_crc(input logic [7:0] msg[$], input logic [31:0] xo);
      logic [31:0] c = 32'hFFFF_FFFF;
      foreach (msg[i]) begin
`ifdef CRC32_REFLECT_EN
         c = c ^ {24'd0, msg[i]};
         repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
`else
         c = c ^ {msg[i], 24'd0};
         repeat (8) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
`endif
      end
      return c ^ xo;
   endfunction

   // Result monitor: every cycle, compare handshaken results with the model queue.
   always @(negedge clk_i) begin
      logic hs;
      hs = rst_n_i && !clr_i && crc_valid_o && crc_ready_i;
      check("valid_pair", 32'(crc_valid_z), 32'(crc_valid_o));
      if (!crc_valid_o) check("idle_crc_zero", crc_o, 32'h0);
      if (prev_valid && !prev_hs && crc_valid_o) check("result_stable", crc_o, prev_crc);
      if (hs) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(1), 32'(0));
         end else begin
            check("crc_result", crc_o, exp_q.pop_front());
            check("crc_result_xor0", crc_z, exp_z_q.pop_front());
         end
      end
      prev_valid = crc_valid_o;
      prev_hs    = hs;
      prev_crc   = crc_o;
   end

   // hold<0 leaves the result pending; abort_at>=0 pulses clr after that word.
   task automatic send_msg(input logic [7:0] msg[$], input int hold, input int abort_at,
                           input bit lit_chk, input logic [31:0] lit, input logic [31:0] lit_z);
      int nw, nb, k;
      logic [31:0] w_data;
      nw = (msg.size() + 3) / 4;
      nb = 0;
      if (abort_at < 0) begin
         exp_q.push_back(model_crc(msg, 32'hFFFF_FFFF));
         exp_z_q.push_back(model_crc(msg, 32'h0));
      end
      for (int w = 0; w < nw; w++) begin
         @(posedge clk_i); #1;
         repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
         nb = msg.size() - 4 * w;
         if (nb > 4) nb = 4;
         w_data = $urandom;
         for (int j = 0; j < nb; j++) w_data[8*j +: 8] = msg[4*w + j];
         in_data_i   = w_data;
         in_last_i   = (w == nw - 1);
         in_nbytes_i = (w == nw - 1) ? 2'(nb - 1) : 2'($urandom);
         in_valid_i  = 1'b1;
         k = 0;
         @(negedge clk_i);
         while (!in_ready_o && k < 50) begin k++; @(negedge clk_i); end
         if (!in_ready_o) begin
            check("accept_timeout", 32'(k), 32'(0));
            in_valid_i = 1'b0;
            return;
         end
         @(posedge clk_i); #1;
         in_valid_i = 1'b0;
         in_last_i  = 1'b0;
         in_data_i  = $urandom;
         if (w == abort_at) begin
            @(negedge clk_i);
            @(negedge clk_i);
            check("busy_before_clr", 32'(busy_o), 32'(1));
            @(posedge clk_i); #1;
            clr_i = 1'b1;
            @(negedge clk_i);
            check("ready_during_clr", 32'(in_ready_o), 32'(0));
            check("valid_during_clr", 32'(crc_valid_o), 32'(0));
            @(posedge clk_i); #1;
            clr_i = 1'b0;
            @(negedge clk_i);
            check("busy_after_clr", 32'(busy_o), 32'(0));
            check("ready_after_clr", 32'(in_ready_o), 32'(1));
            return;
         end
         if (w < nw - 1) begin
            k = 0;
            do begin @(negedge clk_i); k++; end while (!in_ready_o && k < 50);
            check("ready_latency", 32'(k), 32'(5));
         end
      end
      k = 0;
      do begin @(negedge clk_i); k++; end while (!crc_valid_o && k < 50);
      check("valid_latency", 32'(k), 32'(nb + 1));
      check("ready_in_result", 32'(in_ready_o), 32'(0));
      check("busy_in_result", 32'(busy_o), 32'(1));
      if (lit_chk) begin
         check("lit_crc", crc_o, lit);
         check("lit_crc_xor0", crc_z, lit_z);
      end
      if (hold < 0) return;
      repeat (hold) begin
         @(negedge clk_i);
         check("ready_held_low", 32'(in_ready_o), 32'(0));
         check("valid_held", 32'(crc_valid_o), 32'(1));
      end
      @(posedge clk_i); #1;
      crc_ready_i = 1'b1;
      @(posedge clk_i); #1;
      crc_ready_i = 1'b0;
      @(negedge clk_i);
      check("valid_drop", 32'(crc_valid_o), 32'(0));
      check("busy_drop", 32'(busy_o), 32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] m123[$];
      logic [7:0] m0[$];
      logic [7:0] mr[$];
      int len, nw, abort_at;
      m123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      m0   = '{8'h00};

      rst_n_i = 1'b0; clr_i = 1'b0; in_valid_i = 1'b0; in_last_i = 1'b0;
      in_data_i = 32'h0; in_nbytes_i = 2'd0; crc_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("reset_ready", 32'(in_ready_o), 32'(0));
      check("reset_valid", 32'(crc_valid_o), 32'(0));
      check("reset_crc", crc_o, 32'h0);
      check("reset_busy", 32'(busy_o), 32'(0));
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      @(negedge clk_i);
      check("ready_after_reset", 32'(in_ready_o), 32'(1));

      check("model_check_value", model_crc(m123, 32'hFFFF_FFFF), LIT_CHECK);
      check("model_check_xor0", model_crc(m123, 32'h0), LIT_CHECK_Z);
`ifdef CRC32_REFLECT_EN
      check("model_zero_byte", model_crc(m0, 32'hFFFF_FFFF), 32'hD202_EF8D);
`endif

      // Reference message, then a single zero byte.
      send_msg(m123, 1, -1, 1'b1, LIT_CHECK, LIT_CHECK_Z);
`ifdef CRC32_REFLECT_EN
      send_msg(m0, 0, -1, 1'b1, 32'hD202_EF8D, 32'h2DFD_1072);
`else
      send_msg(m0, 0, -1, 1'b0, 32'h0, 32'h0);
`endif

      // Back-pressure on the result port, then an identical repeat.
      send_msg(m123, 10, -1, 1'b1, LIT_CHECK, LIT_CHECK_Z);
      send_msg(m123, 0, -1, 1'b1, LIT_CHECK, LIT_CHECK_Z);

      // Abort during the second word, then the full message again.
      send_msg(m123, 0, 1, 1'b0, 32'h0, 32'h0);
      send_msg(m123, 2, -1, 1'b1, LIT_CHECK, LIT_CHECK_Z);

      // Reset while a result is pending.
      send_msg(m123, -1, -1, 1'b1, LIT_CHECK, LIT_CHECK_Z);
      @(negedge clk_i);
      check("valid_before_reset", 32'(crc_valid_o), 32'(1));
      @(posedge clk_i); #1;
      rst_n_i = 1'b0;
      void'(exp_q.pop_front());
      void'(exp_z_q.pop_front());
      @(negedge clk_i);
      check("ready_in_reset", 32'(in_ready_o), 32'(0));
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      @(negedge clk_i);
      check("valid_after_reset", 32'(crc_valid_o), 32'(0));
      check("crc_after_reset", crc_o, 32'h0);
      check("busy_after_reset", 32'(busy_o), 32'(0));
      check("ready_reset_release", 32'(in_ready_o), 32'(1));
      send_msg(m123, 0, -1, 1'b1, LIT_CHECK, LIT_CHECK_Z);

      // Randomized messages with occasional aborts.
      for (int i = 0; i < 40; i++) begin
         len = $urandom_range(1, 22);
         mr.delete();
         for (int j = 0; j < len; j++) mr.push_back(8'($urandom));
         nw = (len + 3) / 4;
         abort_at = (i % 6 == 5) ? $urandom_range(0, nw - 1) : -1;
         send_msg(mr, $urandom_range(0, 3), abort_at, 1'b0, 32'h0, 32'h0);
      end

      repeat (3) @(negedge clk_i);
      check("pending_results", 32'(exp_q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
